// File: rtl/tmu_edgestep.sv
// One Bresenham-stepped coordinate: 11-bit position plus its error accumulator.
module tmu_edgestep (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [10:0] load_val,
    input  logic        step,
    input  logic        clr_err,
    input  logic        positive,
    input  logic [10:0] q,
    input  logic [10:0] r,
    input  logic [10:0] divisor,
    output logic [10:0] coord
);

    logic [10:0] coord_q, coord_d;
    logic [10:0] err_q, err_d;
    logic [10:0] err_in;
    logic [11:0] e;
    logic [10:0] inc;

    always_comb begin
        coord_d = coord_q;
        err_d   = err_q;
        err_in  = clr_err ? 11'd0 : err_q;
        e       = {1'b0, err_in} + {1'b0, r};
        inc     = q;
        if (e >= {1'b0, divisor}) begin
            inc = q + 11'd1;
        end
        if (load) begin
            coord_d = load_val;
            err_d   = 11'd0;
        end else if (step) begin
            // e - divisor always fits in 11 bits, so the wrap is harmless
            err_d   = (e >= {1'b0, divisor}) ? (e[10:0] - divisor) : e[10:0];
            coord_d = positive ? (coord_q + inc) : (coord_q - inc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coord_q <= 11'd0;
            err_q   <= 11'd0;
        end else begin
            coord_q <= coord_d;
            err_q   <= err_d;
        end
    end

    assign coord = coord_q;

endmodule

// File: rtl/tmu_edgetrace.sv
// Scanline edge tracer: walks Y from A to C, emitting side-1/side-2 X/U/V per line.
module tmu_edgetrace (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        busy,
    input  logic        pipe_stb_i,
    output logic        pipe_ack_o,
    input  logic [10:0] A_S_X,
    input  logic [10:0] A_S_Y,
    input  logic [10:0] A_D_X,
    input  logic [10:0] A_D_Y,
    input  logic [10:0] B_D_Y,
    input  logic [10:0] C_D_Y,
    input  logic        dx1_positive,
    input  logic [10:0] dx1_q,
    input  logic [10:0] dx1_r,
    input  logic        du1_positive,
    input  logic [10:0] du1_q,
    input  logic [10:0] du1_r,
    input  logic        dv1_positive,
    input  logic [10:0] dv1_q,
    input  logic [10:0] dv1_r,
    input  logic        dx2_positive,
    input  logic [10:0] dx2_q,
    input  logic [10:0] dx2_r,
    input  logic        du2_positive,
    input  logic [10:0] du2_q,
    input  logic [10:0] du2_r,
    input  logic        dv2_positive,
    input  logic [10:0] dv2_q,
    input  logic [10:0] dv2_r,
    input  logic        dx3_positive,
    input  logic [10:0] dx3_q,
    input  logic [10:0] dx3_r,
    input  logic        du3_positive,
    input  logic [10:0] du3_q,
    input  logic [10:0] du3_r,
    input  logic        dv3_positive,
    input  logic [10:0] dv3_q,
    input  logic [10:0] dv3_r,
    input  logic [10:0] divisor1,
    input  logic [10:0] divisor2,
    input  logic [10:0] divisor3,
    output logic        pipe_stb_o,
    input  logic        pipe_ack_i,
    output logic [10:0] Y,
    output logic [10:0] X1,
    output logic [10:0] U1,
    output logic [10:0] V1,
    output logic [10:0] X2,
    output logic [10:0] U2,
    output logic [10:0] V2
);

    localparam logic IDLE = 1'b0;
    localparam logic EMIT = 1'b1;

    typedef struct packed {
        logic        pos;
        logic [10:0] q;
        logic [10:0] r;
    } axis_t;

    typedef struct packed {
        axis_t [2:0] ax;
        logic [10:0] div;
    } edge_t;

    logic        state_q, state_d;
    logic [10:0] y_q, y_d;
    logic [10:0] bdy_q, bdy_d;
    logic [10:0] cdy_q, cdy_d;
    edge_t       e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
    edge_t       in_e1, in_e2, in_e3, sel1;
    logic        load, step, clr1;
    logic [10:0] base [3];
    logic [10:0] ld1 [3];
    logic [10:0] ld2 [3];
    logic [10:0] c1 [3];
    logic [10:0] c2 [3];

    always_comb begin
        in_e1.ax[0] = '{dx1_positive, dx1_q, dx1_r};
        in_e1.ax[1] = '{du1_positive, du1_q, du1_r};
        in_e1.ax[2] = '{dv1_positive, dv1_q, dv1_r};
        in_e1.div   = divisor1;
        in_e2.ax[0] = '{dx2_positive, dx2_q, dx2_r};
        in_e2.ax[1] = '{du2_positive, du2_q, du2_r};
        in_e2.ax[2] = '{dv2_positive, dv2_q, dv2_r};
        in_e2.div   = divisor2;
        in_e3.ax[0] = '{dx3_positive, dx3_q, dx3_r};
        in_e3.ax[1] = '{du3_positive, du3_q, du3_r};
        in_e3.ax[2] = '{dv3_positive, dv3_q, dv3_r};
        in_e3.div   = divisor3;
    end

    // Flat top: a zero divisor passes dx through as remainder, landing side 1 on B
    always_comb begin
        base[0] = A_D_X;
        base[1] = A_S_X;
        base[2] = A_S_Y;
        for (int i = 0; i < 3; i++) begin
            ld2[i] = base[i];
            ld1[i] = base[i];
            if (divisor1 == 11'd0) begin
                ld1[i] = in_e1.ax[i].pos ? (base[i] + in_e1.ax[i].r)
                                         : (base[i] - in_e1.ax[i].r);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        bdy_d   = bdy_q;
        cdy_d   = cdy_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        e3_d    = e3_q;
        load    = 1'b0;
        step    = 1'b0;
        clr1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pipe_stb_i) begin
                    load    = 1'b1;
                    state_d = EMIT;
                    y_d     = A_D_Y;
                    bdy_d   = B_D_Y;
                    cdy_d   = C_D_Y;
                    e1_d    = in_e1;
                    e2_d    = in_e2;
                    e3_d    = in_e3;
                end
            end
            EMIT: begin
                if (pipe_ack_i) begin
                    if (y_q == cdy_q) begin
                        state_d = IDLE;
                    end else begin
                        step = 1'b1;
                        y_d  = y_q + 11'd1;
                        clr1 = (y_q == bdy_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel1 = (y_q < bdy_q) ? e1_q : e3_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            y_q     <= 11'd0;
            bdy_q   <= 11'd0;
            cdy_q   <= 11'd0;
            e1_q    <= '0;
            e2_q    <= '0;
            e3_q    <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            bdy_q   <= bdy_d;
            cdy_q   <= cdy_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            e3_q    <= e3_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ax
        tmu_edgestep u_side1 (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .load     (load),
            .load_val (ld1[i]),
            .step     (step),
            .clr_err  (clr1),
            .positive (sel1.ax[i].pos),
            .q        (sel1.ax[i].q),
            .r        (sel1.ax[i].r),
            .divisor  (sel1.div),
            .coord    (c1[i])
        );
        tmu_edgestep u_side2 (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .load     (load),
            .load_val (ld2[i]),
            .step     (step),
            .clr_err  (1'b0),
            .positive (e2_q.ax[i].pos),
            .q        (e2_q.ax[i].q),
            .r        (e2_q.ax[i].r),
            .divisor  (e2_q.div),
            .coord    (c2[i])
        );
    end

    assign busy       = (state_q != IDLE);
    assign pipe_stb_o = (state_q == EMIT);
    assign pipe_ack_o = (state_q == IDLE);
    assign Y          = y_q;
    assign X1         = c1[0];
    assign U1         = c1[1];
    assign V1         = c1[2];
    assign X2         = c2[0];
    assign U2         = c2[1];
    assign V2         = c2[2];

endmodule

// File: tb/tb_tmu_edgetrace.sv
// Randomized bench for tmu_edgetrace against a closed-form scanline model.
module tb_tmu_edgetrace;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        busy, pipe_stb_i, pipe_ack_o, pipe_stb_o, pipe_ack_i;
    logic [10:0] A_S_X, A_S_Y, A_D_X, A_D_Y, B_D_Y, C_D_Y;
    logic        dx1_positive, du1_positive, dv1_positive;
    logic        dx2_positive, du2_positive, dv2_positive;
    logic        dx3_positive, du3_positive, dv3_positive;
    logic [10:0] dx1_q, du1_q, dv1_q, dx2_q, du2_q, dv2_q, dx3_q, du3_q, dv3_q;
    logic [10:0] dx1_r, du1_r, dv1_r, dx2_r, du2_r, dv2_r, dx3_r, du3_r, dv3_r;
    logic [10:0] divisor1, divisor2, divisor3;
    logic [10:0] Y, X1, U1, V1, X2, U2, V2;

    int total = 0;
    int bad = 0;
    int asx, asy, adx, ady, bdy, cdy;
    bit pos [3][3];
    int qv [3][3];
    int rv [3][3];
    int dv [3];
    int cap_x1 [64];
    int cap_x2 [64];

    always #5 sys_clk = ~sys_clk;

    assign A_S_X = asx[10:0];
    assign A_S_Y = asy[10:0];
    assign A_D_X = adx[10:0];
    assign A_D_Y = ady[10:0];
    assign B_D_Y = bdy[10:0];
    assign C_D_Y = cdy[10:0];
    assign dx1_positive = pos[0][0];
    assign du1_positive = pos[0][1];
    assign dv1_positive = pos[0][2];
    assign dx2_positive = pos[1][0];
    assign du2_positive = pos[1][1];
    assign dv2_positive = pos[1][2];
    assign dx3_positive = pos[2][0];
    assign du3_positive = pos[2][1];
    assign dv3_positive = pos[2][2];
    assign dx1_q = qv[0][0][10:0];
    assign du1_q = qv[0][1][10:0];
    assign dv1_q = qv[0][2][10:0];
    assign dx2_q = qv[1][0][10:0];
    assign du2_q = qv[1][1][10:0];
    assign dv2_q = qv[1][2][10:0];
    assign dx3_q = qv[2][0][10:0];
    assign du3_q = qv[2][1][10:0];
    assign dv3_q = qv[2][2][10:0];
    assign dx1_r = rv[0][0][10:0];
    assign du1_r = rv[0][1][10:0];
    assign dv1_r = rv[0][2][10:0];
    assign dx2_r = rv[1][0][10:0];
    assign du2_r = rv[1][1][10:0];
    assign dv2_r = rv[1][2][10:0];
    assign dx3_r = rv[2][0][10:0];
    assign du3_r = rv[2][1][10:0];
    assign dv3_r = rv[2][2][10:0];
    assign divisor1 = dv[0][10:0];
    assign divisor2 = dv[1][10:0];
    assign divisor3 = dv[2][10:0];

    tmu_edgetrace dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .busy(busy),
        .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
        .A_S_X(A_S_X), .A_S_Y(A_S_Y), .A_D_X(A_D_X),
        .A_D_Y(A_D_Y), .B_D_Y(B_D_Y), .C_D_Y(C_D_Y),
        .dx1_positive(dx1_positive), .dx1_q(dx1_q), .dx1_r(dx1_r),
        .du1_positive(du1_positive), .du1_q(du1_q), .du1_r(du1_r),
        .dv1_positive(dv1_positive), .dv1_q(dv1_q), .dv1_r(dv1_r),
        .dx2_positive(dx2_positive), .dx2_q(dx2_q), .dx2_r(dx2_r),
        .du2_positive(du2_positive), .du2_q(du2_q), .du2_r(du2_r),
        .dv2_positive(dv2_positive), .dv2_q(dv2_q), .dv2_r(dv2_r),
        .dx3_positive(dx3_positive), .dx3_q(dx3_q), .dx3_r(dx3_r),
        .du3_positive(du3_positive), .du3_q(du3_q), .du3_r(du3_r),
        .dv3_positive(dv3_positive), .dv3_q(dv3_q), .dv3_r(dv3_r),
        .divisor1(divisor1), .divisor2(divisor2), .divisor3(divisor3),
        .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
        .Y(Y), .X1(X1), .U1(U1), .V1(V1), .X2(X2), .U2(U2), .V2(V2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap(input int v, input bit p, input int d);
        int t;
        t = p ? v + d : v - d;
        return ((t % 2048) + 2048) % 2048;
    endfunction

    // Bresenham from zero error: k steps advance k*q + floor(k*r/div)
    function automatic int adv(input int e, input int a, input int k);
        if (dv[e] == 0) return 0;
        return k * qv[e][a] + (k * rv[e][a]) / dv[e];
    endfunction

    function automatic int mdl(input int side, input int a, input int y);
        int b, v;
        b = (a == 0) ? adx : (a == 1) ? asx : asy;
        if (side == 2) return wrap(b, pos[1][a], adv(1, a, y - ady));
        v = (dv[0] == 0) ? wrap(b, pos[0][a], rv[0][a]) : b;
        if (y <= bdy) return wrap(v, pos[0][a], adv(0, a, y - ady));
        v = wrap(v, pos[0][a], adv(0, a, bdy - ady));
        return wrap(v, pos[2][a], adv(2, a, y - bdy));
    endfunction

    task automatic clear_tri();
        asx = 0; asy = 0; adx = 0; ady = 0; bdy = 0; cdy = 0;
        for (int e = 0; e < 3; e++) begin
            dv[e] = 0;
            for (int a = 0; a < 3; a++) begin
                pos[e][a] = 1'b0; qv[e][a] = 0; rv[e][a] = 0;
            end
        end
    endtask

    task automatic rand_tri();
        int n1, n2;
        ady = $urandom_range(2030, 0);
        n1 = $urandom_range(6, 0);
        n2 = $urandom_range(6, 0);
        bdy = ady + n1;
        cdy = bdy + n2;
        dv[0] = n1; dv[1] = n1 + n2; dv[2] = n2;
        adx = $urandom_range(2047, 0);
        asx = $urandom_range(2047, 0);
        asy = $urandom_range(2047, 0);
        for (int e = 0; e < 3; e++) begin
            for (int a = 0; a < 3; a++) begin
                pos[e][a] = 1'($urandom_range(1, 0));
                qv[e][a] = $urandom_range(5, 0);
                rv[e][a] = (dv[e] != 0) ? $urandom_range(dv[e] - 1, 0)
                                        : $urandom_range(20, 0);
            end
        end
    endtask

    task automatic check_rec(input int y);
        check("stb", int'(pipe_stb_o), 1);
        check("busy", int'(busy), 1);
        check("ack_o", int'(pipe_ack_o), 0);
        check("Y", int'(Y), y);
        check("X1", int'(X1), mdl(1, 0, y));
        check("U1", int'(U1), mdl(1, 1, y));
        check("V1", int'(V1), mdl(1, 2, y));
        check("X2", int'(X2), mdl(2, 0, y));
        check("U2", int'(U2), mdl(2, 1, y));
        check("V2", int'(V2), mdl(2, 2, y));
    endtask

    task automatic accept();
        int w = 0;
        while (!pipe_ack_o && w < 10) begin
            @(posedge sys_clk); #1;
            w++;
        end
        if (w == 10) check("accept_timeout", 0, 1);
        pipe_stb_i = 1'b1;
        @(posedge sys_clk); #1;
        pipe_stb_i = 1'b0;
    endtask

    // mode 0: continuous ack, 1: random ack, 2: 3-cycle stall at Y=A+2
    task automatic run_tri(input int mode);
        int y, g, st;
        bit a;
        accept();
        y = ady; g = 0; st = 0;
        while (y <= cdy && g < 200) begin
            check_rec(y);
            if (y - ady < 64) begin
                cap_x1[y - ady] = int'(X1);
                cap_x2[y - ady] = int'(X2);
            end
            a = 1'b1;
            if (mode == 1) a = 1'($urandom_range(1, 0));
            if (mode == 2 && y == ady + 2 && st < 3) begin
                a = 1'b0;
                st++;
            end
            pipe_ack_i = a;
            @(posedge sys_clk); #1;
            if (a) y++;
            g++;
        end
        if (g == 200) check("record_timeout", 0, 1);
        pipe_ack_i = 1'b0;
        check("stb_after", int'(pipe_stb_o), 0);
        check("ack_o_after", int'(pipe_ack_o), 1);
        check("busy_after", int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stb"}, int'(pipe_stb_o), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ack_o"}, int'(pipe_ack_o), 1);
        check({tag, "_Y"}, int'(Y), 0);
        check({tag, "_X1"}, int'(X1), 0);
        check({tag, "_U1"}, int'(U1), 0);
        check({tag, "_V1"}, int'(V1), 0);
        check({tag, "_X2"}, int'(X2), 0);
        check({tag, "_U2"}, int'(U2), 0);
        check({tag, "_V2"}, int'(V2), 0);
    endtask

    initial begin
        int ex1 [9];
        int ex2 [9];
        sys_rst = 1'b1;
        pipe_stb_i = 1'b0;
        pipe_ack_i = 1'b0;
        clear_tri();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check_zero("reset");

        pipe_ack_i = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("idle_ack_ignored", int'(pipe_stb_o), 0);
        pipe_ack_i = 1'b0;

        clear_tri();
        adx = 10; bdy = 4; cdy = 8;
        pos[0][0] = 1'b1; qv[0][0] = 1; dv[0] = 4;
        qv[1][0] = 1; dv[1] = 8;
        qv[2][0] = 3; dv[2] = 4;
        run_tri(0);
        ex1 = '{10, 11, 12, 13, 14, 11, 8, 5, 2};
        for (int i = 0; i < 9; i++) begin
            check("base_x1", cap_x1[i], ex1[i]);
            check("base_x2", cap_x2[i], 10 - i);
        end

        clear_tri();
        adx = 10; bdy = 4; cdy = 8;
        dv[0] = 4; dv[1] = 8; dv[2] = 4;
        pos[1][0] = 1'b1; rv[1][0] = 3;
        run_tri(0);
        ex2 = '{10, 10, 10, 11, 11, 11, 12, 12, 13};
        for (int i = 0; i < 9; i++) check("rem_x2", cap_x2[i], ex2[i]);

        clear_tri();
        adx = 10; cdy = 2;
        pos[0][0] = 1'b1; rv[0][0] = 6;
        dv[1] = 2;
        qv[2][0] = 3; dv[2] = 2;
        run_tri(0);
        check("flat_x1_0", cap_x1[0], 16);
        check("flat_x1_1", cap_x1[1], 13);
        check("flat_x1_2", cap_x1[2], 10);

        rand_tri();
        ady = 100; bdy = 103; cdy = 108;
        dv[0] = 3; dv[1] = 8; dv[2] = 5;
        for (int a = 0; a < 3; a++) begin
            rv[0][a] = rv[0][a] % 3;
            rv[1][a] = rv[1][a] % 8;
            rv[2][a] = rv[2][a] % 5;
        end
        run_tri(2);

        clear_tri();
        adx = 33; ady = 5; bdy = 5; cdy = 5;
        run_tri(0);
        rand_tri();
        run_tri(0);

        for (int t = 0; t < 40; t++) begin
            rand_tri();
            run_tri(1);
        end

        clear_tri();
        adx = 10; bdy = 4; cdy = 8;
        pos[0][0] = 1'b1; qv[0][0] = 1; dv[0] = 4;
        qv[1][0] = 1; dv[1] = 8;
        qv[2][0] = 3; dv[2] = 4;
        accept();
        pipe_ack_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        pipe_ack_i = 1'b0;
        check("pre_rst_Y", int'(Y), 3);
        check("pre_rst_X1", int'(X1), 13);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check_zero("midrst");
        @(posedge sys_clk); #1;
        check("midrst_no_rec", int'(pipe_stb_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
